// File: rtl/bsg_test_node_pkg.sv
// Shared types and constants for the test-node job scheduler.
package bsg_test_node_pkg;

  // Default payload width of a test-node packet.
  localparam int bsg_test_node_data_width_gp = 64;

  // Width of the client id prefix carried on ring packets.
  localparam int bsg_test_node_id_width_gp = 4;

  // Scheduler phases: waiting for a job, streaming input packets,
  // draining result packets.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } job_state_e;

endpackage

// File: rtl/bsg_test_node_rr_arb.sv
// Combinational round-robin arbiter: picks the first requesting index after
// last_grant_i, wrapping modulo num_req_p.
module bsg_test_node_rr_arb #(
  parameter  int num_req_p   = 4,
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]   req_i,
  input  logic [id_width_lp-1:0] last_grant_i,
  output logic [id_width_lp-1:0] grant_o,
  output logic                   v_o
);

  // Scan the requesters in priority order starting just after the last winner.
  always_comb begin
    logic [id_width_lp-1:0] w_idx;
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would infer a latch.
    w_idx   = '0;
    grant_o = '0;
    v_o     = 1'b0;
    for (int off = 1; off <= num_req_p; off++) begin
      w_idx = id_width_lp'((int'(last_grant_i) + off) % num_req_p);
      if (!v_o && req_i[w_idx]) begin
        v_o     = 1'b1;
        grant_o = w_idx;
      end
    end
  end

endmodule

// File: rtl/bsg_test_node_job_sched.sv
// Time-shares one test-node engine among num_req_p requesters. A job is a
// burst of in_pkts_p packets from the granted requester followed by
// out_pkts_p results returned with that requester's id.
module bsg_test_node_job_sched
  import bsg_test_node_pkg::*;
#(
  parameter  int num_req_p    = 4,
  parameter  int data_width_p = bsg_test_node_data_width_gp,
  parameter  int in_pkts_p    = 16,
  parameter  int out_pkts_p   = 16,
  localparam int id_width_lp  = $clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              eng_v_o,
  output logic [data_width_p-1:0]           eng_data_o,
  input  logic                              eng_ready_i,
  input  logic                              eng_v_i,
  input  logic [data_width_p-1:0]           eng_data_i,
  output logic                              eng_yumi_o,
  output logic                              resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic [id_width_lp-1:0]            resp_id_o,
  input  logic                              resp_yumi_i,
  output logic                              busy_o,
  output logic [15:0]                       jobs_done_o
);

  localparam int in_cnt_w_lp  = $clog2(in_pkts_p + 1);
  localparam int out_cnt_w_lp = $clog2(out_pkts_p + 1);
  localparam logic [in_cnt_w_lp-1:0]  in_last_lp  = in_cnt_w_lp'(in_pkts_p - 1);
  localparam logic [out_cnt_w_lp-1:0] out_last_lp = out_cnt_w_lp'(out_pkts_p - 1);

  job_state_e               r_state;
  logic [id_width_lp-1:0]   r_grant;
  logic [id_width_lp-1:0]   r_last_grant;
  logic [in_cnt_w_lp-1:0]   r_in_cnt;
  logic [out_cnt_w_lp-1:0]  r_out_cnt;
  logic [15:0]              r_jobs_done;

  logic [id_width_lp-1:0]   w_arb_grant;
  logic                     w_arb_v;
  logic                     w_in_hs;
  logic                     w_out_yumi;
  logic [data_width_p-1:0]  w_req_slice [num_req_p];

  // Unpack the flat requester payload bus into one word per requester.
  for (genvar r = 0; r < num_req_p; r++) begin : g_slice
    assign w_req_slice[r] = req_data_i[r*data_width_p +: data_width_p];
  end

  bsg_test_node_rr_arb #(
    .num_req_p (num_req_p)
  ) u_arb (
    .req_i        (req_v_i),
    .last_grant_i (r_last_grant),
    .grant_o      (w_arb_grant),
    .v_o          (w_arb_v)
  );

  // Accepted input packet and consumed result for the job in flight.
  assign w_in_hs    = (r_state == SEND) && req_v_i[r_grant] && eng_ready_i;
  assign w_out_yumi = (r_state == RECV) && eng_v_i && resp_yumi_i;

  // Job sequencing: grant in IDLE, count packets in, count results out.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= id_width_lp'(num_req_p - 1);
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_jobs_done  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (r_state)
        IDLE: begin
          if (en_i && w_arb_v) begin
            r_grant <= w_arb_grant;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_in_hs) begin
            if (r_in_cnt == in_last_lp) begin
              r_in_cnt <= '0;
              r_state  <= RECV;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (w_out_yumi) begin
            if (r_out_cnt == out_last_lp) begin
              r_out_cnt    <= '0;
              r_jobs_done  <= r_jobs_done + 16'd1;
              r_last_grant <= r_grant;
              r_state      <= IDLE;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Steer the granted requester to the engine in SEND and results back in RECV.
  always_comb begin
    eng_v_o     = 1'b0;
    eng_data_o  = '0;
    req_ready_o = '0;
    eng_yumi_o  = 1'b0;
    resp_v_o    = 1'b0;
    resp_data_o = '0;
    case (r_state)
      SEND: begin
        eng_v_o              = req_v_i[r_grant];
        eng_data_o           = w_req_slice[r_grant];
        req_ready_o[r_grant] = eng_ready_i;
      end
      RECV: begin
        resp_v_o    = eng_v_i;
        resp_data_o = eng_data_i;
        eng_yumi_o  = w_out_yumi;
      end
      default: ;
    endcase
  end

  assign resp_id_o   = r_grant;
  assign busy_o      = (r_state != IDLE);
  assign jobs_done_o = r_jobs_done;

endmodule

// File: tb/tb_bsg_test_node_job_sched.sv
// Self-checking bench for bsg_test_node_job_sched: a job-level reference
// model checks every cycle, a vector table covers arbitration order, and
// hand sequences cover stalls, yumi gaps, async reset and enable gating.
module tb_bsg_test_node_job_sched;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int IN  = 16;
  localparam int OUT = 16;
  localparam int IDW = 2;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              en_i;
  logic [N-1:0]      req_v_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              eng_v_o;
  logic [DW-1:0]     eng_data_o;
  logic              eng_ready_i;
  logic              eng_v_i;
  logic [DW-1:0]     eng_data_i;
  logic              eng_yumi_o;
  logic              resp_v_o;
  logic [DW-1:0]     resp_data_o;
  logic [IDW-1:0]    resp_id_o;
  logic              resp_yumi_i;
  logic              busy_o;
  logic [15:0]       jobs_done_o;

  bsg_test_node_job_sched #(
    .num_req_p    (N),
    .data_width_p (DW),
    .in_pkts_p    (IN),
    .out_pkts_p   (OUT)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .req_v_i     (req_v_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .eng_v_o     (eng_v_o),
    .eng_data_o  (eng_data_o),
    .eng_ready_i (eng_ready_i),
    .eng_v_i     (eng_v_i),
    .eng_data_i  (eng_data_i),
    .eng_yumi_o  (eng_yumi_o),
    .resp_v_o    (resp_v_o),
    .resp_data_o (resp_data_o),
    .resp_id_o   (resp_id_o),
    .resp_yumi_i (resp_yumi_i),
    .busy_o      (busy_o),
    .jobs_done_o (jobs_done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int hs_cnt;
  int yu_cnt;
  logic [DW-1:0] slice [N];

  // Job-level reference model: packets still owed in each direction.
  bit m_busy;
  int m_owner, m_last, m_send_left, m_recv_left, m_jobs;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       grant;
    logic [1:0] id;
    logic [15:0] jobs;
  } vec_t;
  vec_t vec [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1;
    m_send_left = 0; m_recv_left = 0; m_jobs = 0;
  endtask

  task automatic rand_data();
    for (int r = 0; r < N; r++) begin
      slice[r] = {$urandom, $urandom};
      req_data_i[r*DW +: DW] = slice[r];
    end
    eng_data_i = {$urandom, $urandom};
  endtask

  task automatic check_outputs();
    bit snd, rcv;
    logic [N-1:0] exp_ready;
    snd = m_busy && (m_send_left > 0);
    rcv = m_busy && (m_send_left == 0);
    exp_ready = '0;
    if (snd) exp_ready[m_owner] = eng_ready_i;
    check("busy", busy_o, m_busy);
    check("jobs_done", jobs_done_o, m_jobs);
    check("eng_v", eng_v_o, snd ? req_v_i[m_owner] : 1'b0);
    check("req_ready", req_ready_o, exp_ready);
    check("eng_yumi", eng_yumi_o, rcv ? (resp_yumi_i & eng_v_i) : 1'b0);
    check("resp_v", resp_v_o, rcv ? eng_v_i : 1'b0);
    if (snd) check("eng_data", eng_data_o, slice[m_owner]);
    if (rcv) check("resp_data", resp_data_o, eng_data_i);
    if (m_busy) check("resp_id", resp_id_o, m_owner);
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (en_i && (req_v_i != '0)) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_v_i[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1; m_send_left = IN; m_recv_left = OUT;
      end
    end else if (m_send_left > 0) begin
      if (req_v_i[m_owner] && eng_ready_i) m_send_left--;
    end else if (eng_v_i && resp_yumi_i) begin
      m_recv_left--;
      if (m_recv_left == 0) begin
        m_busy = 0; m_last = m_owner; m_jobs = (m_jobs + 1) % 65536;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; ends at the next one.
  task automatic cycle();
    #1;
    check_outputs();
    if (eng_v_o && eng_ready_i) hs_cnt++;
    if (eng_yumi_o) yu_cnt++;
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic run_to_idle(input bit rand_yumi);
    for (int c = 0; c < 400; c++) begin
      if (busy_o === 1'b0) break;
      if (rand_yumi) resp_yumi_i = 1'($urandom % 2);
      rand_data();
      cycle();
    end
    check("job_end_busy", busy_o, 1'b0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; en_i = 0; req_v_i = '0; eng_ready_i = 0;
    eng_v_i = 0; resp_yumi_i = 0;
    rand_data();
    model_reset();
    @(negedge clk_i); @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_jobs", jobs_done_o, 16'd0);
    check("rst_id", resp_id_o, 2'd0);
    check("rst_eng_v", eng_v_o, 1'b0);
    check("rst_ready", req_ready_o, 4'd0);
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    //            en    req      grant id    jobs
    vec[0]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 16'd0};
    vec[1]  = '{1'b1, 4'b0001, 1'b1, 2'd0, 16'd1};
    vec[2]  = '{1'b1, 4'b1111, 1'b1, 2'd1, 16'd2};
    vec[3]  = '{1'b1, 4'b1111, 1'b1, 2'd2, 16'd3};
    vec[4]  = '{1'b1, 4'b1111, 1'b1, 2'd3, 16'd4};
    vec[5]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 16'd5};
    vec[6]  = '{1'b1, 4'b0101, 1'b1, 2'd2, 16'd6};
    vec[7]  = '{1'b1, 4'b0101, 1'b1, 2'd0, 16'd7};
    vec[8]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 16'd7};
    vec[9]  = '{1'b1, 4'b1000, 1'b1, 2'd3, 16'd8};
    vec[10] = '{1'b1, 4'b0011, 1'b1, 2'd0, 16'd9};

    do_reset();

    // Arbitration order and full jobs with both sides always ready.
    for (int i = 0; i < 11; i++) begin
      en_i = vec[i].en; req_v_i = vec[i].req;
      eng_ready_i = 1; eng_v_i = 1; resp_yumi_i = 1;
      hs_cnt = 0; yu_cnt = 0;
      rand_data();
      cycle();
      check("tbl_busy", busy_o, vec[i].grant);
      if (vec[i].grant) begin
        check("tbl_id", resp_id_o, vec[i].id);
        check("tbl_ready", req_ready_o, 4'b0001 << vec[i].id);
        run_to_idle(1'b0);
        check("tbl_in_pkts", hs_cnt, IN);
        check("tbl_out_pkts", yu_cnt, OUT);
      end
      check("tbl_jobs", jobs_done_o, vec[i].jobs);
    end

    // Requester 2 drops valid for 5 cycles after packet 7.
    en_i = 1; req_v_i = 4'b0100; hs_cnt = 0; yu_cnt = 0;
    cycle();
    check("stall_id", resp_id_o, 2'd2);
    req_v_i = 4'b1111;
    for (int c = 0; c < 7; c++) begin rand_data(); cycle(); end
    check("stall_pre", hs_cnt, 7);
    req_v_i = 4'b1011;
    for (int c = 0; c < 5; c++) begin rand_data(); cycle(); end
    check("stall_hold", hs_cnt, 7);
    check("stall_busy", busy_o, 1'b1);
    check("stall_owner", resp_id_o, 2'd2);
    req_v_i = 4'b1111;
    run_to_idle(1'b0);
    check("stall_in_pkts", hs_cnt, IN);
    check("stall_jobs", jobs_done_o, 16'd10);

    // 50% resp_yumi with engine results always valid.
    hs_cnt = 0; yu_cnt = 0; resp_yumi_i = 1'($urandom % 2);
    cycle();
    check("yumi_id", resp_id_o, 2'd3);
    run_to_idle(1'b1);
    check("yumi_out_pkts", yu_cnt, OUT);
    check("yumi_jobs", jobs_done_o, 16'd11);

    // Asynchronous reset in the middle of SEND after packet 9.
    resp_yumi_i = 1; req_v_i = 4'b0010; hs_cnt = 0;
    cycle();
    check("arst_pre_id", resp_id_o, 2'd1);
    req_v_i = 4'b1111;
    for (int c = 0; c < 9; c++) begin rand_data(); cycle(); end
    check("arst_pre_pkts", hs_cnt, 9);
    #2 reset_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_eng_v", eng_v_o, 1'b0);
    check("arst_ready", req_ready_o, 4'd0);
    check("arst_yumi", eng_yumi_o, 1'b0);
    check("arst_resp_v", resp_v_o, 1'b0);
    check("arst_jobs", jobs_done_o, 16'd0);
    check("arst_id", resp_id_o, 2'd0);
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
    hs_cnt = 0; yu_cnt = 0;
    cycle();
    check("arst_first_id", resp_id_o, 2'd0);
    run_to_idle(1'b0);
    check("arst_in_pkts", hs_cnt, IN);
    check("arst_jobs_after", jobs_done_o, 16'd1);

    // Enable gating: nothing granted while low, in-flight job completes.
    en_i = 0;
    for (int c = 0; c < 3; c++) begin cycle(); check("en_off_busy", busy_o, 1'b0); end
    en_i = 1; hs_cnt = 0;
    cycle();
    check("en_id", resp_id_o, 2'd1);
    for (int c = 0; c < 100; c++) begin
      if (hs_cnt == IN) break;
      rand_data(); cycle();
    end
    check("en_in_pkts", hs_cnt, IN);
    en_i = 0;
    run_to_idle(1'b0);
    for (int c = 0; c < 3; c++) begin cycle(); check("en_drop_busy", busy_o, 1'b0); end
    check("en_jobs", jobs_done_o, 16'd2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en_i        = ($urandom % 10) != 0;
      req_v_i     = 4'($urandom);
      eng_ready_i = ($urandom % 4) != 0;
      eng_v_i     = ($urandom % 4) != 0;
      resp_yumi_i = ($urandom % 4) != 0;
      rand_data();
      cycle();
    end
    check("rand_jobs_seen", jobs_done_o != 16'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_test_node_job_sched.md
# bsg_test_node_job_sched

Job scheduler that time-shares one test-node compute engine (64-bit data, v/ready input side, v/yumi output side) among `num_req_p` requesters. A job is a fixed-length burst of `in_pkts_p` input packets from one requester, followed by `out_pkts_p` result packets from the engine. Results are routed back to that requester, tagged with its id. The block sits between the ring-facing client logic and the engine instance, so requesters never interleave packets inside one engine job.

## Interface
Parameters:
- `num_req_p`, 4, number of requesters (2..16)
- `data_width_p`, 64, packet payload width
- `in_pkts_p`, 16, input packets per job (>=1)
- `out_pkts_p`, 16, result packets per job (>=1)

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset, asynchronous, active-high
- `en_i`  in  1  when low, no new job is granted; a job in flight completes
- `req_v_i`  in  `num_req_p`  per-requester packet valid
- `req_data_i`  in  `num_req_p*data_width_p`  packed requester payloads, requester r at `[r*data_width_p +: data_width_p]`
- `req_ready_o`  out  `num_req_p`  per-requester ready
- `eng_v_o`  out  1  packet valid to engine
- `eng_data_o`  out  `data_width_p`  packet to engine
- `eng_ready_i`  in  1  engine ready
- `eng_v_i`  in  1  engine result valid
- `eng_data_i`  in  `data_width_p`  engine result
- `eng_yumi_o`  out  1  result consumed
- `resp_v_o`  out  1  result valid to requester side
- `resp_data_o`  out  `data_width_p`  result payload
- `resp_id_o`  out  `$clog2(num_req_p)`  owning requester id
- `resp_yumi_i`  in  1  result consumed downstream
- `busy_o`  out  1  job in flight (state != IDLE)
- `jobs_done_o`  out  16  completed-job count, wraps at 2^16

## Operation
States: IDLE, SEND, RECV.

- **IDLE**: if `en_i` and any `req_v_i` bit is set, register a round-robin grant and go to SEND.
  - Search starts at `last_grant+1` mod `num_req_p`.
  - `last_grant` resets to `num_req_p-1`, so requester 0 wins first.
  - All ready/valid outputs are 0 in IDLE.
- **SEND**:
  - `eng_v_o = req_v_i[grant]`, `eng_data_o` = the granted slice, `req_ready_o[grant] = eng_ready_i`; all other ready bits are 0.
  - Each `eng_v_o & eng_ready_i` increments `in_cnt`.
  - On the handshake where `in_cnt == in_pkts_p-1`: clear `in_cnt` and go to RECV.
  - `eng_yumi_o = 0` in SEND.
- **RECV**:
  - `resp_v_o = eng_v_i`, `resp_data_o = eng_data_i`, `eng_yumi_o = resp_yumi_i & eng_v_i`.
  - Each yumi increments `out_cnt`.
  - On the yumi where `out_cnt == out_pkts_p-1`: clear `out_cnt`, increment `jobs_done_o`, update `last_grant` to grant, go to IDLE.
  - `eng_v_o = 0` and all `req_ready_o = 0` in RECV.
- `resp_id_o` = registered grant, held stable from SEND entry until IDLE.
- `resp_yumi_i` asserted while `resp_v_o` = 0 is ignored, and no count changes.
- Counter widths are `$clog2(in_pkts_p+1)` and `$clog2(out_pkts_p+1)`; the terminal compare is exact, so counters never wrap.
- A requester that drops `req_v_i` mid-job stalls the job in SEND; the grant is not revoked.
- `en_i` falling mid-job has no effect until the return to IDLE.

## Timing
- Reset (async assert, sync-deasserted externally) values:
  - state = IDLE, grant = 0, `last_grant` = `num_req_p-1`, counters = 0, `jobs_done_o` = 0.
  - All `_v_o`, `_ready_o`, `yumi_o` = 0; `busy_o` = 0; `resp_id_o` = 0.
- Reset mid-job returns the block to IDLE immediately, with no partial output. The engine shares `reset_i`.
- Grant latency: a request seen in IDLE at edge N makes `req_ready_o` valid in the cycle after edge N, i.e. one bubble cycle.
- Data paths in SEND and RECV are combinational pass-through; there is no added packet latency.
- Back-to-back jobs: the last result yumi at edge M puts the block in IDLE for cycle M+1. The earliest next-job ready is after edge M+1.
- Full throughput within a job: one packet per cycle when both sides are ready.

## Structure
- Package `bsg_test_node_pkg` holds:
  - the state enum `job_state_e` {IDLE, SEND, RECV};
  - `bsg_test_node_data_width_gp = 64` and `bsg_test_node_id_width_gp = 4`, matching the 4-bit client id prefix on ring packets.
- One sub-module: `bsg_test_node_rr_arb`.
  - Inputs: request vector, `last_grant`.
  - Output: one-hot/encoded grant plus a `v` flag.
  - Purely combinational, registered by the scheduler.

## Test plan
1. Reset, then `req_v_i=4'b0001`, engine always ready, `in_pkts_p=16`, `out_pkts_p=16` -> exactly 16 engine handshakes, then 16 results with `resp_id_o=0`; `jobs_done_o=1`; `busy_o` low one cycle after the last yumi.
2. All four requesters valid continuously for 4 jobs -> grant order 0,1,2,3; `req_ready_o` one-hot to the owner only; `jobs_done_o=4`.
3. Requester 2 drops `req_v_i` for 5 cycles after packet 7 -> job stalls, `in_cnt` holds at 7, no other requester is granted, and the job completes once valid returns.
4. `resp_yumi_i` toggled 50% while `eng_v_i=1` in SEND and RECV -> `eng_yumi_o=0` throughout SEND, and equals `resp_yumi_i` in RECV; exactly 16 results consumed.
5. `reset_i` asserted asynchronously mid-SEND at packet 9 -> outputs go to 0 without a clock edge; after release, requester 0 is granted first again and the counts restart at 0.
6. `en_i=0` with requests pending -> no grant and `busy_o=0`; `en_i` dropped mid-RECV -> the current job finishes and no new grant follows.
